alu32_arbiter: RTL and testbench
================================

# alu32_arbiter

Shares one multi-cycle `alu32` instance between two requesters. Accepts operation requests over a per-requester req/gnt/done handshake and arbitrates round-robin when both request. Holds the selected operands and opcode stable on the ALU inputs for a fixed latency, then captures the ALU output and returns it to the owning requester. It sits between the `alu32` datapath and the two client blocks, for example a command decoder and a test sequencer.

## Interface
Parameters:
- `LATENCY`, default 128: ALU cycles from operand presentation to valid `alu_out`; legal range 1..255.

Ports:
- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `req0`  in  1  requester 0 request, level; `op0`/`a0`/`b0` valid while high
- `op0`  in  3  requester 0 ALUop
- `a0`  in  32  requester 0 operand 1
- `b0`  in  32  requester 0 operand 2
- `gnt0`  out  1  one-cycle pulse: requester 0 operands captured
- `done0`  out  1  one-cycle pulse: `result` belongs to requester 0
- `req1`, `op1`, `a1`, `b1`, `gnt1`, `done1`: same as above, for requester 1
- `result`  out  32  captured ALU result, valid while a `doneN` is high; holds its value afterwards
- `busy`  out  1  high while an operation is in flight
- `alu_op`  out  3  to ALU `ALUop`
- `alu_inp1`  out  32  to ALU `inp1`
- `alu_inp2`  out  32  to ALU `inp2`
- `alu_out`  in  32  from ALU `out`

## Operation
- States: IDLE and RUN; all outputs are registered.
- IDLE, no req: stay in IDLE; `gntN`, `doneN` and `busy` low.
- IDLE, at least one req at edge E0:
  - Select the winner.
  - Load `alu_op`/`alu_inp1`/`alu_inp2` from the winner's `op`/`a`/`b`.
  - Record the owner and set counter = LATENCY-1.
  - Pulse `gntN` and raise `busy`, then go to RUN.
- Arbitration: round-robin with a last-served pointer.
  - Only one req: that requester wins.
  - Both reqs: the requester not last served wins.
  - The pointer updates on each grant; its reset value is 1, so requester 0 wins the first contention.
- RUN, counter != 0: decrement the counter; the ALU inputs stay frozen.
- RUN, counter == 0 at edge Ed:
  - Capture `result <= alu_out`.
  - Pulse `done` for the owner and drop `busy`.
  - Go to IDLE.
- ALU inputs are never cleared after an operation; they hold the last operands.
- Opcodes pass through unmodified; the ALU defines their meaning (000, 010, 011 and 100 are in use).
- A requester may drop req any time after its gnt. A req still high after done is treated as a new request.
- `req`/`op`/`a`/`b` changes during RUN are ignored. No queuing: the losing requester keeps req high and is served next.

## Timing
- Reset values:
  - `gnt0`, `gnt1`, `done0`, `done1`, `busy`: 0
  - `result`, `alu_op`, `alu_inp1`, `alu_inp2`: 0
  - State IDLE, counter 0, pointer 1.
- Grant latency: req sampled high at edge E0 gives gnt high for the cycle after E0. ALU inputs are valid from E0.
- Done latency: Ed = E0 + LATENCY. The ALU sees stable inputs for exactly LATENCY cycles. `done` is high for the cycle after Ed.
- LATENCY=1: Ed = E0+1, so the RUN state lasts one cycle.
- Back-to-back operation: the earliest next grant edge is Ed+1. Throughput is one operation per LATENCY+1 cycles.
- `gntN` and `doneN` are never high together. `gnt0`/`gnt1` are mutually exclusive, and so are `done0`/`done1`.
- RST asserted mid-operation:
  - All outputs clear immediately (asynchronously).
  - The in-flight operation is dropped and no `done` is issued.
  - After RST deasserts, a req held high is re-arbitrated from IDLE.

## Test plan
Bench: behavioural ALU stub returning `inp1+inp2` for op 000 and `inp1-inp2` for op 010, valid LATENCY cycles after the inputs change; LATENCY=128; CLK period 10.
- `req0`, op 000, a=5, b=9 → `gnt0` 1 cycle later; `alu_inp1`=5, `alu_inp2`=9 stable for 128 cycles; `done0` 128 cycles after the grant edge with `result`=0x0000000E.
- `req1`, op 010, a=0xC, b=0x8 → `gnt1`, then `done1` with `result`=0x00000004; `done0` stays 0.
- `req0` and `req1` raised together, both held → order is 0, then 1, then 0; each grant edge is 129 cycles after the previous one.
- RST pulsed 50 cycles into an operation → outputs 0 at once, no `done`; with `req0` still high, `gnt0` is re-issued after RST falls.
- LATENCY=1, continuous `req0`, op 000 (3, 7) → `gnt0` and `done0` alternate on every other cycle; `result`=0x0000000A.
- `a0` changed mid-RUN → `alu_inp1` unchanged; `result` reflects the originally captured operands.

Source files
------------

// File: rtl/alu32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu32_arbiter
// Purpose  : Shares one multi-cycle alu32 between two requesters. A request is
//            granted (round-robin on contention), its operands and opcode are
//            held on the ALU inputs for LATENCY cycles, then the ALU output is
//            captured and returned to the owning requester with a done pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LATENCY   ALU cycles from operand presentation to valid alu_out (1..255)
// Ports
//   CLK        in   1   system clock, rising edge
//   RST        in   1   asynchronous active-high reset
//   req0/req1  in   1   level request; opN/aN/bN valid while high
//   op0/op1    in   3   requester ALU opcode
//   a0/a1      in  32   requester operand 1
//   b0/b1      in  32   requester operand 2
//   gnt0/gnt1  out  1   one-cycle pulse: requester operands captured
//   done0/done1 out 1   one-cycle pulse: result belongs to that requester
//   result     out 32   captured ALU result (holds after done)
//   busy       out  1   operation in flight
//   alu_op     out  3   to ALU ALUop
//   alu_inp1   out 32   to ALU inp1
//   alu_inp2   out 32   to ALU inp2
//   alu_out    in  32   from ALU out
// ============================================================================
module alu32_arbiter #(
  parameter int LATENCY = 128
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic [2:0]  op0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  output logic        gnt0,
  output logic        done0,
  input  logic        req1,
  input  logic [2:0]  op1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt1,
  output logic        done1,
  output logic [31:0] result,
  output logic        busy,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_inp1,
  output logic [31:0] alu_inp2,
  input  logic [31:0] alu_out
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Counter is loaded with LATENCY-1 at the grant edge and reaches zero on
  // the edge exactly LATENCY cycles later, which is the capture edge.
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       last_q;   // last-served requester; reset to 1 so 0 wins first
  logic       owner_q;  // requester owning the in-flight operation

  // Requester 1 wins when it is alone, or when both request and requester 0
  // was the one served last.
  logic sel1;
  assign sel1 = req1 & (~req0 | ~last_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      result   <= 32'd0;
      alu_op   <= 3'd0;
      alu_inp1 <= 32'd0;
      alu_inp2 <= 32'd0;
    end else begin
      // Handshake outputs are single-cycle pulses by default.
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            alu_op   <= sel1 ? op1 : op0;
            alu_inp1 <= sel1 ? a1  : a0;
            alu_inp2 <= sel1 ? b1  : b0;
            owner_q  <= sel1;
            last_q   <= sel1;
            cnt_q    <= CNT_INIT;
            gnt0     <= ~sel1;
            gnt1     <= sel1;
            busy     <= 1'b1;
            state_q  <= S_RUN;
          end
        end

        S_RUN: begin
          // ALU inputs are left untouched here so they stay frozen for the
          // whole operation and keep the last operands afterwards.
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            result  <= alu_out;
            done0   <= ~owner_q;
            done1   <= owner_q;
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu32_arbiter
// Purpose  : Scoreboard bench for alu32_arbiter. Two instances: LATENCY=128
//            driven through the main scenarios, LATENCY=1 for the fast
//            alternating-grant case. A behavioural ALU stub returns garbage
//            until its inputs have been stable long enough.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu32_arbiter;

  localparam int LAT = 128;

  typedef struct {
    int          ev;   // 0 gnt0, 1 gnt1, 2 done0, 3 done1
    int          cyc;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];    // expectations for the LATENCY=128 instance
  exp_t sb1[$];   // expectations for the LATENCY=1 instance

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  // LATENCY=128 instance signals
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [2:0]  op0 = 3'd0, op1 = 3'd0;
  logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [31:0] result, alu_inp1, alu_inp2, alu_out;
  logic [2:0]  alu_op;

  // LATENCY=1 instance signals
  logic        l1_req0 = 1'b0, l1_req1 = 1'b0;
  logic [2:0]  l1_op0 = 3'd0, l1_op1 = 3'd0;
  logic [31:0] l1_a0 = 32'd0, l1_b0 = 32'd0, l1_a1 = 32'd0, l1_b1 = 32'd0;
  logic        l1_gnt0, l1_gnt1, l1_done0, l1_done1, l1_busy;
  logic [31:0] l1_result, l1_inp1, l1_inp2, l1_alu_out;
  logic [2:0]  l1_alu_op;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  alu32_arbiter #(.LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
    .result(result), .busy(busy),
    .alu_op(alu_op), .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_out(alu_out)
  );

  alu32_arbiter #(.LATENCY(1)) dut1 (
    .CLK(CLK), .RST(RST),
    .req0(l1_req0), .op0(l1_op0), .a0(l1_a0), .b0(l1_b0), .gnt0(l1_gnt0), .done0(l1_done0),
    .req1(l1_req1), .op1(l1_op1), .a1(l1_a1), .b1(l1_b1), .gnt1(l1_gnt1), .done1(l1_done1),
    .result(l1_result), .busy(l1_busy),
    .alu_op(l1_alu_op), .alu_inp1(l1_inp1), .alu_inp2(l1_inp2), .alu_out(l1_alu_out)
  );

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      3'b000:  return x + y;
      3'b010:  return x - y;
      default: return x ^ y;
    endcase
  endfunction

  // ALU stub: output is only meaningful once inputs have been stable for
  // LAT cycles (counted in edges since the change), otherwise DEADBEEF.
  logic [66:0] prev_in = '0;
  logic [7:0]  stab    = 8'd0;
  always @(posedge CLK) begin
    if ({alu_op, alu_inp1, alu_inp2} != prev_in) stab <= 8'd1;
    else if (stab != 8'd255)                     stab <= stab + 8'd1;
    prev_in <= {alu_op, alu_inp1, alu_inp2};
  end
  assign alu_out    = (stab >= 8'(LAT - 1)) ? alu_f(alu_op, alu_inp1, alu_inp2) : 32'hDEAD_BEEF;
  assign l1_alu_out = alu_f(l1_alu_op, l1_inp1, l1_inp2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push(input int which, input int ev, input int c, input logic [31:0] res);
    exp_t e;
    e.ev = ev; e.cyc = c; e.res = res;
    if (which == 0) sb.push_back(e);
    else            sb1.push_back(e);
  endtask

  // Monitor: any handshake pulse pops the next expectation of that instance.
  task automatic mon_one(input int which, input logic g0, input logic g1,
                         input logic d0, input logic d1, input logic [31:0] res);
    int   n;
    int   ev;
    exp_t e;
    n = int'(g0) + int'(g1) + int'(d0) + int'(d1);
    if (n == 0) return;
    ev = g0 ? 0 : g1 ? 1 : d0 ? 2 : 3;
    checks++;
    if ((which == 0 ? sb.size() : sb1.size()) == 0) begin
      errors++;
      $display("FAIL sb%0d unexpected: event %0d at cycle %0d, want no event", which, ev, cyc);
      return;
    end
    e = (which == 0) ? sb.pop_front() : sb1.pop_front();
    if (n != 1 || ev != e.ev || cyc != e.cyc || (ev >= 2 && res !== e.res)) begin
      errors++;
      $display("FAIL sb%0d event: got ev %0d (pulses %0d) cyc %0d res %h, want ev %0d cyc %0d res %h",
               which, ev, n, cyc, res, e.ev, e.cyc, e.res);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      mon_one(0, gnt0, gnt1, done0, done1, result);
      mon_one(1, l1_gnt0, l1_gnt1, l1_done0, l1_done1, l1_result);
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((sb.size() != 0 || sb1.size() != 0) && n < maxc) begin
      @(negedge CLK); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending events, want 0/0", sb.size(), sb1.size());
      sb.delete();
      sb1.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int m;

    // Reset values
    #1;
    chk("rst gnt0",   {31'd0, gnt0}, 32'd0);
    chk("rst busy",   {31'd0, busy}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst inp1",   alu_inp1, 32'd0);
    chk("rst inp2",   alu_inp2, 32'd0);
    chk("rst op",     {29'd0, alu_op}, 32'd0);
    chk("rst l1 out", {l1_gnt0, l1_done0, l1_busy, l1_result[28:0]}, 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 1: requester 0 add, operand change mid-run is ignored
    k = cyc;
    req0 = 1'b1; op0 = 3'b000; a0 = 32'd5; b0 = 32'd9;
    push(0, 0, k + 1, 32'd0);
    push(0, 2, k + 1 + LAT, 32'h0000_000E);
    @(negedge CLK);
    req0 = 1'b0;
    chk("t1 busy", {31'd0, busy}, 32'd1);
    chk("t1 inp1", alu_inp1, 32'd5);
    chk("t1 inp2", alu_inp2, 32'd9);
    for (int i = 2; i <= LAT; i++) begin
      @(negedge CLK);
      if (i == 60) a0 = 32'd77;
      chk("t1 hold", {busy, alu_inp1[15:0], alu_inp2[14:0]}, {1'b1, 16'd5, 15'd9});
    end
    drain(20);
    chk("t1 result", result, 32'h0000_000E);
    chk("t1 busy off", {31'd0, busy}, 32'd0);
    chk("t1 inp1 kept", alu_inp1, 32'd5);

    // 2: requester 1 subtract
    @(negedge CLK);
    k = cyc;
    req1 = 1'b1; op1 = 3'b010; a1 = 32'hC; b1 = 32'h8;
    push(0, 1, k + 1, 32'd0);
    push(0, 3, k + 1 + LAT, 32'h0000_0004);
    @(negedge CLK);
    req1 = 1'b0;
    chk("t2 op", {29'd0, alu_op}, 32'd2);
    drain(LAT + 20);
    chk("t2 result", result, 32'h0000_0004);

    // 3: contention, round-robin 0,1,0 with LAT+1 spacing
    @(negedge CLK);
    k = cyc;
    req0 = 1'b1; op0 = 3'b000; a0 = 32'd1;  b0 = 32'd2;
    req1 = 1'b1; op1 = 3'b010; a1 = 32'd10; b1 = 32'd3;
    push(0, 0, k + 1,                32'd0);
    push(0, 2, k + 1 + LAT,          32'd3);
    push(0, 1, k + 2 + LAT,          32'd0);
    push(0, 3, k + 2 + 2 * LAT,      32'd7);
    push(0, 0, k + 3 + 2 * LAT,      32'd0);
    push(0, 2, k + 3 + 3 * LAT,      32'd3);
    wait_cyc(k + 3 + 2 * LAT);
    req0 = 1'b0; req1 = 1'b0;
    drain(LAT + 20);

    // 4: reset mid-operation, re-arbitration of held req0
    @(negedge CLK);
    k = cyc;
    req0 = 1'b1; op0 = 3'b000; a0 = 32'd20; b0 = 32'd22;
    push(0, 0, k + 1, 32'd0);
    wait_cyc(k + 51);
    RST = 1'b1;
    #1;
    chk("t4 busy",   {31'd0, busy}, 32'd0);
    chk("t4 inp1",   alu_inp1, 32'd0);
    chk("t4 result", result, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    m = cyc;
    push(0, 0, m + 1, 32'd0);
    push(0, 2, m + 1 + LAT, 32'd42);
    @(negedge CLK);
    req0 = 1'b0;
    drain(LAT + 20);
    chk("t4 result", result, 32'd42);

    // 5: LATENCY=1, continuous req0 -> gnt/done alternate
    @(negedge CLK);
    k = cyc;
    l1_req0 = 1'b1; l1_op0 = 3'b000; l1_a0 = 32'd3; l1_b0 = 32'd7;
    for (int i = 0; i < 3; i++) begin
      push(1, 0, k + 1 + 2 * i, 32'd0);
      push(1, 2, k + 2 + 2 * i, 32'h0000_000A);
    end
    wait_cyc(k + 5);
    l1_req0 = 1'b0;
    drain(20);
    chk("t5 result", l1_result, 32'h0000_000A);
    chk("t5 busy",   {31'd0, l1_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
